i2c_page_writer: RTL and testbench

Upstream feeder for the i2c_master write path. It buffers host bytes in an internal FIFO and accepts a write request (start address plus byte count). It splits the request into page-aligned bursts and drives the master's en/dat_addr/tx_len/tx_byte for each burst. Between bursts it holds the bus idle for the EEPROM internal write cycle. It runs on the same divided clock as i2c_master.

---
 rtl/i2c_page_writer.sv | 214 +++++++++++++++++++++
 tb/tb_i2c_page_writer.sv | 497 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_page_writer.sv
// Host-byte FIFO feeding i2c_master: splits a write request into page-aligned bursts with an
// idle write-cycle gap after each. Define I2C_WR_STAT_EN to build the burst_cnt counter.
module i2c_page_writer #(
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned PAGE_SIZE  = 32,
  parameter int unsigned WC_CNT     = 500
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [7:0]                  push_data,
  output logic                        fifo_full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  input  logic                        wr_req,
  input  logic [15:0]                 wr_addr,
  input  logic [7:0]                  wr_cnt,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic                        m_en,
  output logic                        m_read_mode,
  output logic [15:0]                 m_dat_addr,
  output logic [7:0]                  m_tx_len,
  output logic [7:0]                  m_tx_byte,
  input  logic                        m_tx_ready,
  output logic [15:0]                 burst_cnt
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned PgW  = $clog2(PAGE_SIZE);
  localparam int unsigned WcW  = (WC_CNT > 1) ? $clog2(WC_CNT) : 1;

  typedef enum logic [2:0] {StIdle, StLoad, StBurst, StWaitWc, StDone} state_e;

  state_e state_q, state_d;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0] level_q, level_d;
  logic            push_ok, pop;

  logic [15:0]    addr_q, addr_d;
  logic [7:0]     rem_q, rem_d;
  logic [7:0]     blen_q, blen_d;
  logic [7:0]     bcnt_q, bcnt_d;
  logic [WcW-1:0] wc_q, wc_d;
  logic           busy_q, busy_d;
  logic           err_q, err_d;
  logic           m_en_q, m_en_d;
  logic [15:0]    m_dat_addr_q, m_dat_addr_d;
  logic [7:0]     m_tx_len_q, m_tx_len_d;
  logic [7:0]     m_tx_byte_q, m_tx_byte_d;
  logic           ready_q, ready_fall;

  logic [8:0] page_space;
  logic [7:0] blen;

  assign fifo_full  = (level_q == LvlW'(FIFO_DEPTH));
  assign fifo_level = level_q;
  assign push_ok    = push & ~fifo_full;
  assign ready_fall = ready_q & ~m_tx_ready;

  // Bytes left in the current page, capped by the bytes still owed.
  assign page_space = 9'(PAGE_SIZE) - 9'(addr_q[PgW-1:0]);
  assign blen       = (9'(rem_q) < page_space) ? rem_q : page_space[7:0];

  assign busy        = busy_q;
  assign err         = err_q;
  assign done        = (state_q == StDone);
  assign m_en        = m_en_q;
  assign m_read_mode = 1'b0;
  assign m_dat_addr  = m_dat_addr_q;
  assign m_tx_len    = m_tx_len_q;
  assign m_tx_byte   = m_tx_byte_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    blen_d       = blen_q;
    bcnt_d       = bcnt_q;
    wc_d         = wc_q;
    busy_d       = busy_q;
    err_d        = 1'b0;
    m_en_d       = m_en_q;
    m_dat_addr_d = m_dat_addr_q;
    m_tx_len_d   = m_tx_len_q;
    m_tx_byte_d  = m_tx_byte_q;
    pop          = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (wr_req) begin
          // Level check reserves every byte of the request before it starts.
          if (wr_cnt == 8'd0 || 16'(level_q) < 16'(wr_cnt)) begin
            err_d = 1'b1;
          end else begin
            addr_d  = wr_addr;
            rem_d   = wr_cnt;
            busy_d  = 1'b1;
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        m_dat_addr_d = addr_q;
        m_tx_len_d   = blen - 8'd1;
        blen_d       = blen;
        bcnt_d       = 8'd0;
        m_tx_byte_d  = mem[rd_ptr_q];
        pop          = 1'b1;
        m_en_d       = 1'b1;
        state_d      = StBurst;
      end
      StBurst: begin
        if (ready_fall) begin
          bcnt_d = bcnt_q + 8'd1;
          if (bcnt_d < blen_q) begin
            m_tx_byte_d = mem[rd_ptr_q];
            pop         = 1'b1;
          end else begin
            m_en_d  = 1'b0;
            addr_d  = addr_q + 16'(blen_q);
            rem_d   = rem_q - blen_q;
            wc_d    = '0;
            state_d = StWaitWc;
          end
        end
      end
      StWaitWc: begin
        if (wc_q == WcW'(WC_CNT - 1)) begin
          state_d = (rem_q != 8'd0) ? StLoad : StDone;
        end else begin
          wc_d = wc_q + WcW'(1);
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    level_d = level_q;
    if (push_ok && !pop) begin
      level_d = level_q + LvlW'(1);
    end else if (!push_ok && pop) begin
      level_d = level_q - LvlW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      addr_q       <= '0;
      rem_q        <= '0;
      blen_q       <= '0;
      bcnt_q       <= '0;
      wc_q         <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      m_en_q       <= 1'b0;
      m_dat_addr_q <= '0;
      m_tx_len_q   <= '0;
      m_tx_byte_q  <= '0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
      level_q      <= level_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      blen_q       <= blen_d;
      bcnt_q       <= bcnt_d;
      wc_q         <= wc_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      m_en_q       <= m_en_d;
      m_dat_addr_q <= m_dat_addr_d;
      m_tx_len_q   <= m_tx_len_d;
      m_tx_byte_q  <= m_tx_byte_d;
      ready_q      <= m_tx_ready;
    end
  end

`ifdef I2C_WR_STAT_EN
  logic [15:0] burst_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt_q <= '0;
    end else if (state_q == StBurst && state_d == StWaitWc && burst_cnt_q != 16'hFFFF) begin
      burst_cnt_q <= burst_cnt_q + 16'd1;
    end
  end

  assign burst_cnt = burst_cnt_q;
`else
  assign burst_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_i2c_page_writer.sv
// Self-checking bench for i2c_page_writer: a responder stands in for i2c_master and a
// queue-based model predicts bursts, byte order, gaps and FIFO level.
module tb_i2c_page_writer;

  localparam int unsigned Depth  = 64;
  localparam int unsigned Page   = 32;
  localparam int unsigned Wc     = 500;
  localparam int unsigned Budget = 20000;

`ifdef I2C_WR_STAT_EN
  localparam bit StatEn = 1'b1;
`else
  localparam bit StatEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        push = 1'b0;
  logic [7:0]  push_data = 8'd0;
  logic        wr_req = 1'b0;
  logic [15:0] wr_addr = 16'd0;
  logic [7:0]  wr_cnt = 8'd0;
  logic        m_tx_ready = 1'b0;
  logic        fifo_full, busy, done, err, m_en, m_read_mode;
  logic [6:0]  fifo_level;
  logic [15:0] m_dat_addr, burst_cnt;
  logic [7:0]  m_tx_len, m_tx_byte;

  int total = 0;
  int bad = 0;

  i2c_page_writer #(
    .FIFO_DEPTH(Depth),
    .PAGE_SIZE (Page),
    .WC_CNT    (Wc)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_data  (push_data),
    .fifo_full  (fifo_full),
    .fifo_level (fifo_level),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_cnt     (wr_cnt),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .m_en       (m_en),
    .m_read_mode(m_read_mode),
    .m_dat_addr (m_dat_addr),
    .m_tx_len   (m_tx_len),
    .m_tx_byte  (m_tx_byte),
    .m_tx_ready (m_tx_ready),
    .burst_cnt  (burst_cnt)
  );

  always #5 clk = ~clk;

  // Observations gathered by the master responder.
  logic [15:0] obs_addr[$];
  logic [7:0]  obs_len[$];
  logic [7:0]  obs_bytes[$];
  int          obs_gap[$];
  int          obs_done[$];
  int          cyc = 0;
  int          last_fall = 0;
  int          hold = 0;
  int          wait_n = 0;
  bit          en_seen = 1'b0;
  bit          fell_now = 1'b0;

  // Reference model state.
  logic [7:0]  mq[$];
  logic [15:0] exp_addr[$];
  logic [7:0]  exp_len[$];
  logic [7:0]  exp_bytes[$];
  int          stat_exp = 0;
  int          b_burst, b_byte, b_done;

  // i2c_master stand-in: raises tx_ready, drops it to consume the byte on m_tx_byte.
  always @(posedge clk) begin
    #1;
    cyc++;
    fell_now = 1'b0;
    if (done) obs_done.push_back(cyc);
    if (!m_en) begin
      if (en_seen) begin
        en_seen   = 1'b0;
        last_fall = cyc;
      end
      m_tx_ready = 1'b0;
      wait_n     = 0;
    end else begin
      if (!en_seen) begin
        en_seen = 1'b1;
        obs_addr.push_back(m_dat_addr);
        obs_len.push_back(m_tx_len);
        obs_gap.push_back(cyc - last_fall);
      end
      if (m_tx_ready) begin
        if (hold == 0) begin
          obs_bytes.push_back(m_tx_byte);
          m_tx_ready = 1'b0;
          fell_now   = 1'b1;
          wait_n     = $urandom_range(0, 3);
        end else begin
          hold--;
        end
      end else if (wait_n == 0) begin
        m_tx_ready = 1'b1;
        hold       = $urandom_range(0, 2);
      end else begin
        wait_n--;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    stat_exp = 0;
  endtask

  task automatic push_bytes(input int n, input bit rnd, input logic [7:0] start);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      push      = 1'b1;
      push_data = rnd ? 8'($urandom) : start + 8'(i);
      if (mq.size() < Depth) mq.push_back(push_data);
    end
    @(negedge clk);
    push = 1'b0;
  endtask

  // Plans the expected bursts from page arithmetic and issues the request pulse.
  task automatic start_req(input logic [15:0] a, input logic [7:0] c);
    int unsigned ad, r, b;
    ad = a;
    r  = c;
    exp_addr.delete();
    exp_len.delete();
    exp_bytes.delete();
    while (r > 0) begin
      b = Page - (ad % Page);
      if (r < b) b = r;
      exp_addr.push_back(16'(ad));
      exp_len.push_back(8'(b - 1));
      ad = (ad + b) % 65536;
      r  = r - b;
    end
    for (int i = 0; i < int'(c); i++) exp_bytes.push_back(mq.pop_front());
    b_burst = obs_addr.size();
    b_byte  = obs_bytes.size();
    b_done  = obs_done.size();
    @(negedge clk);
    wr_req  = 1'b1;
    wr_addr = a;
    wr_cnt  = c;
    @(negedge clk);
    wr_req  = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int n = 0;
    while (obs_done.size() == b_done && n < Budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    ok = (obs_done.size() > b_done);
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({busy, done, err, m_en, fifo_full, fifo_level} !== 12'd0) begin
      bad++;
      $display("FAIL reset_ctrl: busy=%b done=%b err=%b m_en=%b full=%b level=%0d want all 0",
               busy, done, err, m_en, fifo_full, fifo_level);
    end
    total++;
    if ({m_dat_addr, m_tx_len, m_tx_byte, burst_cnt, m_read_mode} !== 49'd0) begin
      bad++;
      $display("FAIL reset_data: addr=%h len=%h byte=%h bcnt=%h rd=%b want all 0",
               m_dat_addr, m_tx_len, m_tx_byte, burst_cnt, m_read_mode);
    end
    do_reset();
    total++;
    if ({busy, m_en, fifo_level} !== 9'd0) begin
      bad++;
      $display("FAIL reset_release: busy=%b m_en=%b level=%0d want 0", busy, m_en, fifo_level);
    end
  endtask

  task automatic test_single_page();
    bit ok;
    int nb, nbytes;
    push_bytes(32, 1'b0, 8'h00);
    start_req(16'h0000, 8'd32);
    wait_done(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_done: no done within %0d cycles", Budget); end
    nb = obs_addr.size() - b_burst;
    total++;
    if (nb != 1 || obs_addr[b_burst] !== 16'h0000 || obs_len[b_burst] !== 8'd31) begin
      bad++;
      $display("FAIL single_burst: n=%0d addr=%h len=%0d want n=1 addr=0000 len=31", nb,
               obs_addr[b_burst], obs_len[b_burst]);
    end
    nbytes = obs_bytes.size() - b_byte;
    total++;
    if (nbytes != 32) begin bad++; $display("FAIL single_nbytes: got %0d want 32", nbytes); end
    for (int i = 0; i < nbytes && i < 32; i++) begin
      total++;
      if (obs_bytes[b_byte+i] !== exp_bytes[i]) begin
        bad++;
        $display("FAIL single_byte%0d: got %h want %h", i, obs_bytes[b_byte+i], exp_bytes[i]);
      end
    end
    total++;
    if (ok && obs_done[b_done] - last_fall != Wc) begin
      bad++;
      $display("FAIL single_wc: done %0d cycles after burst want %0d",
               obs_done[b_done] - last_fall, Wc);
    end
    total++;
    if (fifo_level !== 7'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_end: level=%0d busy=%b want 0 0", fifo_level, busy);
    end
    if (ok) stat_exp += exp_addr.size();
  endtask

  task automatic test_cross_page();
    bit ok;
    int nb, nbytes;
    logic [15:0] exp_bc;
    push_bytes(40, 1'b1, 8'h00);
    start_req(16'h001C, 8'd40);
    wait_done(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL cross_done: no done within %0d cycles", Budget); end
    nb = obs_addr.size() - b_burst;
    total++;
    if (nb != exp_addr.size()) begin
      bad++;
      $display("FAIL cross_nburst: got %0d want %0d", nb, exp_addr.size());
    end
    for (int i = 0; i < nb && i < exp_addr.size(); i++) begin
      total++;
      if (obs_addr[b_burst+i] !== exp_addr[i] || obs_len[b_burst+i] !== exp_len[i]) begin
        bad++;
        $display("FAIL cross_burst%0d: addr=%h len=%0d want addr=%h len=%0d", i,
                 obs_addr[b_burst+i], obs_len[b_burst+i], exp_addr[i], exp_len[i]);
      end
      if (i > 0) begin
        total++;
        if (obs_gap[b_burst+i] != Wc + 1) begin
          bad++;
          $display("FAIL cross_gap%0d: m_en low %0d cycles want %0d", i, obs_gap[b_burst+i],
                   Wc + 1);
        end
      end
    end
    nbytes = obs_bytes.size() - b_byte;
    total++;
    if (nbytes != 40) begin bad++; $display("FAIL cross_nbytes: got %0d want 40", nbytes); end
    for (int i = 0; i < nbytes && i < 40; i++) begin
      total++;
      if (obs_bytes[b_byte+i] !== exp_bytes[i]) begin
        bad++;
        $display("FAIL cross_byte%0d: got %h want %h", i, obs_bytes[b_byte+i], exp_bytes[i]);
      end
    end
    if (ok) stat_exp += exp_addr.size();
    exp_bc = StatEn ? 16'(stat_exp) : 16'd0;
    total++;
    if (burst_cnt !== exp_bc) begin
      bad++;
      $display("FAIL cross_stat: burst_cnt=%0d want %0d", burst_cnt, exp_bc);
    end
  endtask

  task automatic test_reject();
    bit en_hit = 1'b0;
    push_bytes(5, 1'b1, 8'h00);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      wr_req  = 1'b1;
      wr_addr = 16'($urandom);
      wr_cnt  = (k == 0) ? 8'd8 : 8'd0;
      @(posedge clk);
      #1;
      total++;
      if (err !== 1'b1 || busy !== 1'b0) begin
        bad++;
        $display("FAIL reject_err%0d: err=%b busy=%b want 1 0", k, err, busy);
      end
      @(negedge clk);
      wr_req = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk);
        #1;
        if (m_en) en_hit = 1'b1;
      end
      total++;
      if (en_hit || err !== 1'b0 || fifo_level !== 7'(mq.size())) begin
        bad++;
        $display("FAIL reject_idle%0d: m_en_seen=%b err=%b level=%0d want 0 0 %0d", k, en_hit,
                 err, fifo_level, mq.size());
      end
    end
  endtask

  task automatic test_full();
    bit ok;
    int n = 0;
    int nb, nbytes;
    logic [6:0] lvl;
    push_bytes(Depth - mq.size(), 1'b1, 8'h00);
    total++;
    if (fifo_full !== 1'b1 || fifo_level !== 7'(Depth)) begin
      bad++;
      $display("FAIL full_fill: full=%b level=%0d want 1 %0d", fifo_full, fifo_level, Depth);
    end
    push_bytes(1, 1'b1, 8'h00);
    total++;
    if (fifo_full !== 1'b1 || fifo_level !== 7'(Depth)) begin
      bad++;
      $display("FAIL full_drop: full=%b level=%0d want 1 %0d", fifo_full, fifo_level, Depth);
    end
    // Crosses 0xFFFF so the second burst wraps to address 0.
    start_req(16'hFFF0, 8'd32);
    while (!fell_now && n < Budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    lvl       = fifo_level;
    push      = 1'b1;
    push_data = 8'($urandom);
    mq.push_back(push_data);
    @(posedge clk);
    #2;
    push = 1'b0;
    total++;
    if (!fell_now && n >= Budget || fifo_level !== lvl) begin
      bad++;
      $display("FAIL full_pushpop: level=%0d want %0d", fifo_level, lvl);
    end
    wait_done(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL full_done: no done within %0d cycles", Budget); end
    nb = obs_addr.size() - b_burst;
    total++;
    if (nb != exp_addr.size()) begin
      bad++;
      $display("FAIL full_nburst: got %0d want %0d", nb, exp_addr.size());
    end
    for (int i = 0; i < nb && i < exp_addr.size(); i++) begin
      total++;
      if (obs_addr[b_burst+i] !== exp_addr[i] || obs_len[b_burst+i] !== exp_len[i]) begin
        bad++;
        $display("FAIL full_burst%0d: addr=%h len=%0d want addr=%h len=%0d", i,
                 obs_addr[b_burst+i], obs_len[b_burst+i], exp_addr[i], exp_len[i]);
      end
    end
    nbytes = obs_bytes.size() - b_byte;
    for (int i = 0; i < nbytes && i < exp_bytes.size(); i++) begin
      total++;
      if (obs_bytes[b_byte+i] !== exp_bytes[i]) begin
        bad++;
        $display("FAIL full_byte%0d: got %h want %h", i, obs_bytes[b_byte+i], exp_bytes[i]);
      end
    end
    total++;
    if (nbytes != 32 || fifo_level !== 7'(mq.size())) begin
      bad++;
      $display("FAIL full_end: bytes=%0d level=%0d want 32 %0d", nbytes, fifo_level, mq.size());
    end
    if (ok) stat_exp += exp_addr.size();
  endtask

  task automatic test_reset_mid();
    int n = 0;
    logic [15:0] a;
    a = 16'(($urandom & 32'hFFE0) | $urandom_range(0, Page - 11));
    start_req(a, 8'd20);
    while (obs_bytes.size() - b_byte < 5 && n < Budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    wr_req = 1'b1;
    wr_cnt = 8'd0;
    @(posedge clk);
    #2;
    wr_req = 1'b0;
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL midreq_err: err=%b want 0", err); end
    while (obs_bytes.size() - b_byte < 10 && n < Budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    total++;
    if (obs_bytes.size() - b_byte < 10) begin
      bad++;
      $display("FAIL mid_progress: %0d bytes want 10", obs_bytes.size() - b_byte);
    end
    for (int i = 0; i < 10 && b_byte + i < obs_bytes.size(); i++) begin
      total++;
      if (obs_bytes[b_byte+i] !== exp_bytes[i]) begin
        bad++;
        $display("FAIL mid_byte%0d: got %h want %h", i, obs_bytes[b_byte+i], exp_bytes[i]);
      end
    end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (m_en !== 1'b0 || fifo_level !== 7'd0 || busy !== 1'b0 || burst_cnt !== 16'd0) begin
      bad++;
      $display("FAIL mid_reset: m_en=%b level=%0d busy=%b bcnt=%0d want 0 0 0 0", m_en,
               fifo_level, busy, burst_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    stat_exp = 0;
  endtask

  task automatic test_random();
    bit ok;
    int nb, nbytes, space;
    logic [7:0] c;
    logic [15:0] exp_bc;
    for (int it = 0; it < 3; it++) begin
      space = Depth - mq.size();
      if (space > 0) push_bytes($urandom_range(1, space), 1'b1, 8'h00);
      c = 8'($urandom_range(1, mq.size()));
      start_req(16'($urandom), c);
      wait_done(ok);
      nb     = obs_addr.size() - b_burst;
      nbytes = obs_bytes.size() - b_byte;
      total++;
      if (!ok || nb != exp_addr.size() || nbytes != int'(c)) begin
        bad++;
        $display("FAIL rand%0d_shape: done=%b bursts=%0d bytes=%0d want 1 %0d %0d", it, ok, nb,
                 nbytes, exp_addr.size(), c);
      end
      for (int i = 0; i < nb && i < exp_addr.size(); i++) begin
        total++;
        if (obs_addr[b_burst+i] !== exp_addr[i] || obs_len[b_burst+i] !== exp_len[i]) begin
          bad++;
          $display("FAIL rand%0d_burst%0d: addr=%h len=%0d want addr=%h len=%0d", it, i,
                   obs_addr[b_burst+i], obs_len[b_burst+i], exp_addr[i], exp_len[i]);
        end
      end
      for (int i = 0; i < nbytes && i < exp_bytes.size(); i++) begin
        total++;
        if (obs_bytes[b_byte+i] !== exp_bytes[i]) begin
          bad++;
          $display("FAIL rand%0d_byte%0d: got %h want %h", it, i, obs_bytes[b_byte+i],
                   exp_bytes[i]);
        end
      end
      if (ok) stat_exp += exp_addr.size();
      exp_bc = StatEn ? 16'(stat_exp) : 16'd0;
      total++;
      if (fifo_level !== 7'(mq.size()) || busy !== 1'b0 || burst_cnt !== exp_bc) begin
        bad++;
        $display("FAIL rand%0d_end: level=%0d busy=%b bcnt=%0d want %0d 0 %0d", it, fifo_level,
                 busy, burst_cnt, mq.size(), exp_bc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_page();
    test_cross_page();
    test_reject();
    test_full();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
